// File: rtl/bat_pkg.sv
// Shared definitions for the Bat Amateur bus-register family.
package bat_pkg;
    typedef enum logic {
        MODE_WRAP = 1'b0,
        MODE_SAT  = 1'b1
    } mode_e;

    localparam int DEFAULT_BUS_WIDTH = 16;
endpackage

// File: rtl/bidi_step_unit.sv
// Combinational up/down stepper with programmable modulus and wrap/saturate
// handling; flags any range excursion on overflow.
module bidi_step_unit
    import bat_pkg::*;
#(
    parameter int                   BUS_WIDTH  = DEFAULT_BUS_WIDTH,
    parameter int                   STEP_WIDTH = 4,
    parameter logic [BUS_WIDTH-1:0] MAX_VALUE  = '1,
    parameter mode_e                MODE       = MODE_WRAP
) (
    input  logic [BUS_WIDTH-1:0]  value,
    input  logic [STEP_WIDTH-1:0] step,
    input  logic                  down,
    output logic [BUS_WIDTH-1:0]  result,
    output logic                  overflow
);
    // One extra bit so MAX_VALUE+1 (the modulus) and value+step never overflow.
    localparam logic [BUS_WIDTH:0] MAX_EXT = {1'b0, MAX_VALUE};
    localparam logic [BUS_WIDTH:0] MODULUS = MAX_EXT + 1'b1;

    logic [BUS_WIDTH:0] val_ext;
    logic [BUS_WIDTH:0] step_ext;
    logic [BUS_WIDTH:0] sum;
    logic [BUS_WIDTH:0] wide;

    always_comb begin
        val_ext  = {1'b0, value};
        step_ext = (BUS_WIDTH+1)'(step);
        sum      = val_ext + step_ext;
        wide     = sum;
        overflow = 1'b0;
        if (!down) begin
            if (sum > MAX_EXT) begin
                overflow = 1'b1;
                wide     = (MODE == MODE_SAT) ? MAX_EXT : sum - MODULUS;
            end
        end else if (step_ext > val_ext) begin
            overflow = 1'b1;
            wide     = (MODE == MODE_SAT) ? '0 : val_ext + MODULUS - step_ext;
        end else begin
            wide = val_ext - step_ext;
        end
        result = wide[BUS_WIDTH-1:0];
    end
endmodule

// File: rtl/bidi_count_register.sv
// Bidirectional bus register with optional modulo/saturating step counter
// and a sticky event flag (wrap, saturation or load clamp).
module bidi_count_register
    import bat_pkg::*;
#(
    parameter int                   BUS_WIDTH   = DEFAULT_BUS_WIDTH,
    parameter int                   STEP_WIDTH  = 4,
    parameter logic [BUS_WIDTH-1:0] MAX_VALUE   = '1,
    parameter logic [BUS_WIDTH-1:0] RESET_VALUE = '0,
    parameter mode_e                MODE        = MODE_WRAP,
    parameter bit                   COUNT_EN    = 1'b1
) (
    input  logic                  CLOCK,
    input  logic                  RESET,
    input  logic                  RW,
    input  logic                  ENABLE,
    input  logic                  COUNT,
    input  logic                  DOWN,
    input  logic [STEP_WIDTH-1:0] STEP,
    input  logic                  FLAG_CLR,
    inout  wire  [BUS_WIDTH-1:0]  DATA,
    output logic                  ZERO,
    output logic                  AT_MAX,
    output logic                  EVENT
);
    logic [BUS_WIDTH-1:0] value;
    logic [BUS_WIDTH-1:0] step_next;
    logic                 step_evt;
    logic                 load;
    logic                 load_clamp;
    logic                 do_count;

    assign load       = ENABLE && !RW;
    assign load_clamp = DATA > MAX_VALUE;
    assign do_count   = COUNT_EN && COUNT && !load;

    generate
        if (COUNT_EN) begin : g_count
            bidi_step_unit #(
                .BUS_WIDTH (BUS_WIDTH),
                .STEP_WIDTH(STEP_WIDTH),
                .MAX_VALUE (MAX_VALUE),
                .MODE      (MODE)
            ) u_step (
                .value   (value),
                .step    (STEP),
                .down    (DOWN),
                .result  (step_next),
                .overflow(step_evt)
            );

            // A step larger than the whole range has no meaningful result.
            assert property (@(posedge CLOCK) disable iff (RESET)
                do_count |-> ((BUS_WIDTH+1)'(STEP) <= {1'b0, MAX_VALUE}));
        end else begin : g_hold
            assign step_next = value;
            assign step_evt  = 1'b0;
        end
    endgenerate

    always_ff @(posedge CLOCK or posedge RESET) begin
        if (RESET) begin
            value <= RESET_VALUE;
            EVENT <= 1'b0;
        end else begin
            if (load)
                value <= load_clamp ? MAX_VALUE : DATA;
            else if (do_count)
                value <= step_next;

            // Set beats clear when both happen on the same edge.
            if ((load && load_clamp) || (do_count && step_evt))
                EVENT <= 1'b1;
            else if (FLAG_CLR)
                EVENT <= 1'b0;
        end
    end

    assign DATA   = (ENABLE && RW && !RESET) ? value : 'z;
    assign ZERO   = (value == '0);
    assign AT_MAX = (value == MAX_VALUE);
endmodule

// File: tb/tb_bidi_count_register.sv
// Three 8-bit instances (wrap/9, sat/9, wrap/0x7F) on shared stimulus,
// checked against an arithmetic reference model.
module tb_bidi_count_register;
    import bat_pkg::*;

    localparam int N = 3;
    localparam int RST_VAL = 5;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       en = 1'b1, rw = 1'b1, cnt = 1'b0, dn = 1'b0, clr = 1'b0;
    logic [3:0] stp = '0;
    logic       bus_drv = 1'b0;
    logic [7:0] bus_val = '0;

    wire [7:0]   data0, data1, data2;
    wire [N-1:0] zero, at_max, evt;

    assign data0 = bus_drv ? bus_val : 8'hzz;
    assign data1 = bus_drv ? bus_val : 8'hzz;
    assign data2 = bus_drv ? bus_val : 8'hzz;

    int max_c[N] = '{9, 9, 127};
    bit sat_c[N] = '{1'b0, 1'b1, 1'b0};
    int mval[N];
    bit mevt[N];
    int total = 0;
    int bad = 0;

    always #5 clk = ~clk;

    bidi_count_register #(.BUS_WIDTH(8), .MAX_VALUE(8'd9), .RESET_VALUE(8'd5), .MODE(MODE_WRAP)) u_wrap (
        .CLOCK(clk), .RESET(rst), .RW(rw), .ENABLE(en), .COUNT(cnt), .DOWN(dn), .STEP(stp),
        .FLAG_CLR(clr), .DATA(data0), .ZERO(zero[0]), .AT_MAX(at_max[0]), .EVENT(evt[0]));
    bidi_count_register #(.BUS_WIDTH(8), .MAX_VALUE(8'd9), .RESET_VALUE(8'd5), .MODE(MODE_SAT)) u_sat (
        .CLOCK(clk), .RESET(rst), .RW(rw), .ENABLE(en), .COUNT(cnt), .DOWN(dn), .STEP(stp),
        .FLAG_CLR(clr), .DATA(data1), .ZERO(zero[1]), .AT_MAX(at_max[1]), .EVENT(evt[1]));
    bidi_count_register #(.BUS_WIDTH(8), .MAX_VALUE(8'h7f), .RESET_VALUE(8'd5), .MODE(MODE_WRAP)) u_wide (
        .CLOCK(clk), .RESET(rst), .RW(rw), .ENABLE(en), .COUNT(cnt), .DOWN(dn), .STEP(stp),
        .FLAG_CLR(clr), .DATA(data2), .ZERO(zero[2]), .AT_MAX(at_max[2]), .EVENT(evt[2]));

    function automatic logic [7:0] get_data(input int i);
        case (i)
            0:       return data0;
            1:       return data1;
            default: return data2;
        endcase
    endfunction

    task automatic chk(input string tag, input int idx, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s[%0d] t=%0t got=%h exp=%h", tag, idx, $time, got, exp);
        end
    endtask

    task automatic check_flags(input string tag);
        for (int i = 0; i < N; i++) begin
            chk({tag, "_zero"},  i, 32'(zero[i]),   32'(mval[i] == 0));
            chk({tag, "_atmax"}, i, 32'(at_max[i]), 32'(mval[i] == max_c[i]));
            chk({tag, "_event"}, i, 32'(evt[i]),    32'(mevt[i]));
        end
    endtask

    // Bus must show the stored value when driven outward, otherwise float.
    task automatic check_bus(input string tag);
        logic [7:0] exp;
        for (int i = 0; i < N; i++) begin
            if (en && rw && !rst) exp = 8'(mval[i]);
            else                  exp = 8'hzz;
            chk({tag, "_data"}, i, 32'(get_data(i)), 32'(exp));
        end
    endtask

    task automatic model_reset();
        for (int i = 0; i < N; i++) begin
            mval[i] = RST_VAL;
            mevt[i] = 1'b0;
        end
    endtask

    task automatic model_edge(input bit e, input bit r, input bit c, input bit d, input int s,
                              input bit fc, input int ld);
        for (int i = 0; i < N; i++) begin
            bit set = 1'b0;
            if (e && !r) begin
                if (ld > max_c[i]) begin mval[i] = max_c[i]; set = 1'b1; end
                else mval[i] = ld;
            end else if (c) begin
                int t = d ? mval[i] - s : mval[i] + s;
                if (t > max_c[i]) begin
                    set = 1'b1;
                    t = sat_c[i] ? max_c[i] : t - (max_c[i] + 1);
                end else if (t < 0) begin
                    set = 1'b1;
                    t = sat_c[i] ? 0 : t + (max_c[i] + 1);
                end
                mval[i] = t;
            end
            if (set) mevt[i] = 1'b1;
            else if (fc) mevt[i] = 1'b0;
        end
    endtask

    // Entered just after a rising edge; checks the bus mid-cycle, then flags after the edge.
    task automatic cycle(input string tag, input bit e, input bit r, input bit c, input bit d,
                         input int s, input bit fc, input int ld);
        en = e; rw = r; cnt = c; dn = d; stp = 4'(s); clr = fc;
        bus_drv = e && !r;
        bus_val = 8'(ld);
        #2;
        if (!(e && !r)) check_bus(tag);
        @(posedge clk);
        #1;
        model_edge(e, r, c, d, s, fc, ld);
        check_flags(tag);
    endtask

    task automatic async_reset();
        en = 1'b1; rw = 1'b1; cnt = 1'b1; dn = 1'b0; stp = 4'd3; bus_drv = 1'b0;
        #3 rst = 1'b1;
        #1;
        model_reset();
        check_flags("arst");
        check_bus("arst");
        #1 rst = 1'b0;
    endtask

    initial begin
        model_reset();
        #7;
        check_flags("por");
        check_bus("por");
        #1 rst = 1'b0;

        //           tag       en rw cnt dn stp clr load
        cycle("rdrst",  1, 1, 0, 0, 0, 0, 0);
        cycle("ld8",    1, 0, 0, 0, 0, 0, 8);
        cycle("up3",    0, 0, 1, 0, 3, 0, 0);
        cycle("rd1",    1, 1, 0, 0, 0, 0, 0);
        cycle("dn2",    0, 1, 1, 1, 2, 0, 0);
        cycle("rd2",    1, 1, 0, 0, 0, 0, 0);
        cycle("ld1",    1, 0, 0, 0, 0, 1, 1);
        cycle("dn4",    0, 0, 1, 1, 4, 0, 0);
        cycle("rd3",    1, 1, 0, 0, 0, 0, 0);
        cycle("ld42c",  1, 0, 1, 0, 5, 0, 8'h42);
        cycle("rd4",    1, 1, 0, 0, 0, 0, 0);
        cycle("ldff",   1, 0, 0, 0, 0, 1, 8'hff);
        cycle("rd5",    1, 1, 0, 0, 0, 0, 0);
        cycle("ld8b",   1, 0, 0, 0, 0, 1, 8);
        cycle("clrlose",0, 0, 1, 0, 3, 1, 0);
        cycle("clr",    0, 0, 0, 0, 0, 1, 0);
        cycle("step0",  1, 1, 1, 0, 0, 0, 0);
        cycle("rdcnt1", 1, 1, 1, 0, 1, 0, 0);
        cycle("rdcnt2", 1, 1, 1, 0, 1, 0, 0);
        cycle("rd6",    1, 1, 0, 0, 0, 0, 0);
        cycle("rwlo",   0, 1, 0, 0, 0, 0, 0);

        async_reset();
        cycle("rdarst", 1, 1, 0, 0, 0, 0, 0);

        for (int k = 0; k < 400; k++) begin
            cycle("rnd", 1'($urandom), 1'($urandom), 1'($urandom), 1'($urandom),
                  int'($urandom_range(0, 9)), ($urandom % 4) == 0, int'($urandom % 256));
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
